// File: rtl/scan_code_frame_controller.sv
// rtl/scan_code_frame_controller.sv - frames the debounced serial keyboard link into scan-code key events
module scan_code_frame_controller #(
   parameter int TIMEOUT_CYCLES = 2000,
   parameter int CNT_W          = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       SERIAL_CLK,
   input  logic       SERIAL_DATA,
   input  logic       KEY_READY,
   input  logic       OVR_CLR,
   output logic       KEY_VALID,
   output logic [7:0] KEY_CODE,
   output logic       KEY_EXT,
   output logic       KEY_RELEASE,
   output logic       FRAME_ERR,
   output logic [1:0] ERR_CODE,
   output logic       OVERRUN
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] ERR_TIMEOUT = 2'b00;
   localparam logic [1:0] ERR_START   = 2'b01;
   localparam logic [1:0] ERR_PARITY  = 2'b10;
   localparam logic [1:0] ERR_STOP    = 2'b11;

   // Synchronisers idle high so a line that is low at reset release
   // still produces one clean falling edge.
   logic sclk_s1_q, sclk_s2_q, sclk_dly_q;
   logic sdat_s1_q, sdat_s2_q;
   logic fall;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sclk_s1_q  <= 1'b1;
         sclk_s2_q  <= 1'b1;
         sclk_dly_q <= 1'b1;
         sdat_s1_q  <= 1'b1;
         sdat_s2_q  <= 1'b1;
      end else begin
         sclk_s1_q  <= SERIAL_CLK;
         sclk_s2_q  <= sclk_s1_q;
         sclk_dly_q <= sclk_s2_q;
         sdat_s1_q  <= SERIAL_DATA;
         sdat_s2_q  <= sdat_s1_q;
      end
   end

   assign fall = sclk_dly_q & ~sclk_s2_q;

   state_t           state_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shift_q;
   logic             par_err_q;
   logic [CNT_W-1:0] cnt_q;
   logic             frame_err_q;
   logic [1:0]       err_code_q;
   logic             byte_ok_q;
   logic [7:0]       byte_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'h00;
         par_err_q   <= 1'b0;
         cnt_q       <= '0;
         frame_err_q <= 1'b0;
         err_code_q  <= 2'b00;
         byte_ok_q   <= 1'b0;
         byte_q      <= 8'h00;
      end else begin
         frame_err_q <= 1'b0;
         byte_ok_q   <= 1'b0;

         if (fall || state_q == ST_IDLE) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end

         if (fall) begin
            case (state_q)
               ST_IDLE: begin
                  if (sdat_s2_q) begin
                     frame_err_q <= 1'b1;
                     err_code_q  <= ERR_START;
                  end else begin
                     state_q   <= ST_DATA;
                     bit_idx_q <= 3'd0;
                     par_err_q <= 1'b0;
                  end
               end
               ST_DATA: begin
                  // LSB arrives first, so shift in from the top.
                  shift_q   <= {sdat_s2_q, shift_q[7:1]};
                  bit_idx_q <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= ST_PARITY;
                  end
               end
               ST_PARITY: begin
                  par_err_q <= (sdat_s2_q != ~^shift_q);
                  state_q   <= ST_STOP;
               end
               ST_STOP: begin
                  state_q <= ST_IDLE;
                  if (!sdat_s2_q) begin
                     frame_err_q <= 1'b1;
                     err_code_q  <= ERR_STOP;
                  end else if (par_err_q) begin
                     frame_err_q <= 1'b1;
                     err_code_q  <= ERR_PARITY;
                  end else begin
                     byte_ok_q <= 1'b1;
                     byte_q    <= shift_q;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end else if (state_q != ST_IDLE && cnt_q == TO_LAST) begin
            state_q     <= ST_IDLE;
            frame_err_q <= 1'b1;
            err_code_q  <= ERR_TIMEOUT;
         end
      end
   end

   // Prefix decode: E0/F0 only arm flags; any other good byte becomes an event.
   logic       ext_q, rel_q;
   logic       evt_q;
   logic [7:0] evt_code_q;
   logic       evt_ext_q, evt_rel_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ext_q      <= 1'b0;
         rel_q      <= 1'b0;
         evt_q      <= 1'b0;
         evt_code_q <= 8'h00;
         evt_ext_q  <= 1'b0;
         evt_rel_q  <= 1'b0;
      end else begin
         evt_q <= 1'b0;
         if (frame_err_q) begin
            ext_q <= 1'b0;
            rel_q <= 1'b0;
         end else if (byte_ok_q) begin
            if (byte_q == 8'hE0) begin
               ext_q <= 1'b1;
            end else if (byte_q == 8'hF0) begin
               rel_q <= 1'b1;
            end else begin
               evt_q      <= 1'b1;
               evt_code_q <= byte_q;
               evt_ext_q  <= ext_q;
               evt_rel_q  <= rel_q;
               ext_q      <= 1'b0;
               rel_q      <= 1'b0;
            end
         end
      end
   end

   logic       key_valid_q, key_valid_d;
   logic [7:0] key_code_q;
   logic       key_ext_q, key_rel_q;
   logic       overrun_q, overrun_d;
   logic       key_load, evt_drop;

   // A slot freed by acceptance in this cycle can take the new event.
   always_comb begin
      evt_drop    = evt_q & key_valid_q & ~KEY_READY;
      key_load    = evt_q & ~evt_drop;
      key_valid_d = key_valid_q;
      if (key_load) begin
         key_valid_d = 1'b1;
      end else if (key_valid_q & KEY_READY) begin
         key_valid_d = 1'b0;
      end
      overrun_d = overrun_q;
      if (evt_drop) begin
         overrun_d = 1'b1;
      end else if (OVR_CLR) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         key_valid_q <= 1'b0;
         key_code_q  <= 8'h00;
         key_ext_q   <= 1'b0;
         key_rel_q   <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         key_valid_q <= key_valid_d;
         overrun_q   <= overrun_d;
         if (key_load) begin
            key_code_q <= evt_code_q;
            key_ext_q  <= evt_ext_q;
            key_rel_q  <= evt_rel_q;
         end
      end
   end

   assign KEY_VALID   = key_valid_q;
   assign KEY_CODE    = key_code_q;
   assign KEY_EXT     = key_ext_q;
   assign KEY_RELEASE = key_rel_q;
   assign FRAME_ERR   = frame_err_q;
   assign ERR_CODE    = err_code_q;
   assign OVERRUN     = overrun_q;

endmodule

// File: tb/tb_scan_code_frame_controller.sv
// tb/tb_scan_code_frame_controller.sv - randomized frame stimulus checked against a frame-level reference model
module tb_scan_code_frame_controller;

   localparam int TO = 64;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       SERIAL_CLK = 1'b1;
   logic       SERIAL_DATA = 1'b1;
   logic       KEY_READY = 1'b0;
   logic       OVR_CLR = 1'b0;
   logic       KEY_VALID;
   logic [7:0] KEY_CODE;
   logic       KEY_EXT;
   logic       KEY_RELEASE;
   logic       FRAME_ERR;
   logic [1:0] ERR_CODE;
   logic       OVERRUN;

   scan_code_frame_controller #(
      .TIMEOUT_CYCLES(TO),
      .CNT_W(8)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .SERIAL_CLK(SERIAL_CLK),
      .SERIAL_DATA(SERIAL_DATA),
      .KEY_READY(KEY_READY),
      .OVR_CLR(OVR_CLR),
      .KEY_VALID(KEY_VALID),
      .KEY_CODE(KEY_CODE),
      .KEY_EXT(KEY_EXT),
      .KEY_RELEASE(KEY_RELEASE),
      .FRAME_ERR(FRAME_ERR),
      .ERR_CODE(ERR_CODE),
      .OVERRUN(OVERRUN)
   );

   initial forever #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
      end
   endtask

   // Reference model: falls are scheduled by the driver, frames are judged as whole 11-bit words.
   typedef struct packed {
      logic [31:0] t;
      logic        b;
   } fall_t;
   typedef struct packed {
      logic [31:0] t;
      logic [7:0]  code;
      logic        ext;
      logic        rel;
   } ev_t;

   fall_t      fq[$];
   ev_t        evq[$];
   logic       bits[$];
   int         last_proc = 0;
   logic       m_vld = 0, m_ext = 0, m_rel = 0, m_err = 0, m_ovr = 0;
   logic [7:0] m_code = 0;
   logic [1:0] m_ecode = 0;
   logic       f_ext = 0, f_rel = 0;
   logic       m_acc, m_load, m_oset;
   fall_t      mf;
   ev_t        me;

   task automatic raise_err(input logic [1:0] c);
      m_err   = 1'b1;
      m_ecode = c;
      f_ext   = 1'b0;
      f_rel   = 1'b0;
   endtask

   task automatic frame_bit(input logic b);
      logic [7:0] by;
      ev_t        e;
      if (bits.size() == 0) begin
         if (b) raise_err(2'b01);
         else bits.push_back(b);
      end else begin
         bits.push_back(b);
         if (bits.size() == 11) begin
            for (int i = 0; i < 8; i++) by[i] = bits[1+i];
            if (!bits[10]) raise_err(2'b11);
            else if ((^by) == bits[9]) raise_err(2'b10);
            else if (by == 8'hE0) f_ext = 1'b1;
            else if (by == 8'hF0) f_rel = 1'b1;
            else begin
               e.t = 32'(cyc + 2);
               e.code = by;
               e.ext = f_ext;
               e.rel = f_rel;
               evq.push_back(e);
               f_ext = 1'b0;
               f_rel = 1'b0;
            end
            bits.delete();
         end
      end
   endtask

   initial forever begin
      @(posedge CLK);
      cyc = cyc + 1;
      if (RST) begin
         fq.delete(); evq.delete(); bits.delete();
         m_vld = 0; m_ext = 0; m_rel = 0; m_err = 0; m_ovr = 0;
         m_code = 0; m_ecode = 0; f_ext = 0; f_rel = 0;
      end else begin
         m_acc = m_vld && KEY_READY;
         m_err = 1'b0;
         if (fq.size() > 0 && fq[0].t == 32'(cyc)) begin
            mf = fq.pop_front();
            last_proc = cyc;
            frame_bit(mf.b);
         end else if (bits.size() > 0 && cyc == last_proc + TO) begin
            raise_err(2'b00);
            bits.delete();
         end
         m_load = 1'b0;
         m_oset = 1'b0;
         if (evq.size() > 0 && evq[0].t == 32'(cyc)) begin
            me = evq.pop_front();
            if (m_vld && !KEY_READY) m_oset = 1'b1;
            else begin
               m_load = 1'b1;
               m_code = me.code;
               m_ext  = me.ext;
               m_rel  = me.rel;
            end
         end
         if (m_load) m_vld = 1'b1;
         else if (m_acc) m_vld = 1'b0;
         if (m_oset) m_ovr = 1'b1;
         else if (OVR_CLR) m_ovr = 1'b0;
      end
   end

   // Compare process plus a log of observed events and errors for the directed checks.
   int         n_acc = 0, n_err = 0, rise_cyc = 0, last_ecyc = 0;
   logic [7:0] a_code = 0;
   logic       a_ext = 0, a_rel = 0, pv = 0;
   logic [1:0] last_ecode = 0;

   initial forever begin
      @(negedge CLK);
      #1;
      if (!RST) begin
         chk("frame_err", FRAME_ERR, m_err);
         if (m_err) chk("err_code", ERR_CODE, m_ecode);
         chk("key_valid", KEY_VALID, m_vld);
         if (m_vld) begin
            chk("key_code", KEY_CODE, m_code);
            chk("key_ext", KEY_EXT, m_ext);
            chk("key_release", KEY_RELEASE, m_rel);
         end
         chk("overrun", OVERRUN, m_ovr);
         if (FRAME_ERR) begin
            n_err++;
            last_ecode = ERR_CODE;
            last_ecyc = cyc;
         end
         if (KEY_VALID && KEY_READY) begin
            n_acc++;
            a_code = KEY_CODE;
            a_ext = KEY_EXT;
            a_rel = KEY_RELEASE;
         end
         if (KEY_VALID && !pv) rise_cyc = cyc;
         pv = KEY_VALID;
      end else begin
         pv = 1'b0;
      end
   end

   // Stimulus
   int   last_drive = 0;
   logic rand_rdy = 0;
   logic stall = 0;

   task automatic send_bit(input logic b);
      int    h;
      int    l;
      fall_t f;
      h = $urandom_range(2, 6);
      l = $urandom_range(2, 6);
      @(negedge CLK);
      SERIAL_DATA = b;
      repeat (h) @(negedge CLK);
      SERIAL_CLK = 1'b0;
      last_drive = cyc;
      f.t = 32'(cyc + 3);
      f.b = b;
      fq.push_back(f);
      repeat (l) @(negedge CLK);
      SERIAL_CLK = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] by, input logic pflip, input logic stop, input int nb);
      logic [10:0] fr;
      fr = {stop, (~^by) ^ pflip, by, 1'b0};
      for (int i = 0; i < nb; i++) send_bit(fr[i]);
   endtask

   task automatic settle();
      @(negedge CLK);
      #3;
   endtask

   task automatic ready_driver();
      forever begin
         @(negedge CLK);
         if (rand_rdy) begin
            KEY_READY = stall ? 1'b0 : ($urandom_range(0, 9) < 6);
            OVR_CLR = ($urandom_range(0, 31) == 0);
         end
      end
   endtask

   task automatic run_random(input int nframes);
      int         sel;
      int         kind;
      logic [7:0] by;
      for (int n = 0; n < nframes; n++) begin
         stall = ($urandom_range(0, 3) == 0);
         sel = $urandom_range(0, 99);
         if (sel < 20) by = 8'hE0;
         else if (sel < 35) by = 8'hF0;
         else by = 8'($urandom_range(0, 255));
         kind = $urandom_range(0, 99);
         if (kind < 8) send_frame(by, 1'b1, 1'b1, 11);
         else if (kind < 15) send_frame(by, 1'b0, 1'b0, 11);
         else if (kind < 21) begin
            send_frame(by, 1'b0, 1'b1, $urandom_range(1, 10));
            repeat (TO + 5) @(negedge CLK);
         end else send_frame(by, 1'b0, 1'b1, 11);
         repeat ($urandom_range(0, 15)) @(negedge CLK);
      end
   endtask

   int a0, e0;

   initial begin
      fork
         ready_driver();
      join_none

      repeat (3) settle();
      chk("rst_key_valid", KEY_VALID, 0);
      chk("rst_key_code", KEY_CODE, 0);
      chk("rst_key_ext", KEY_EXT, 0);
      chk("rst_key_release", KEY_RELEASE, 0);
      chk("rst_frame_err", FRAME_ERR, 0);
      chk("rst_err_code", ERR_CODE, 0);
      chk("rst_overrun", OVERRUN, 0);
      @(negedge CLK);
      RST = 1'b0;
      KEY_READY = 1'b1;
      repeat (5) settle();

      a0 = n_acc; e0 = n_err;
      send_frame(8'h1C, 1'b0, 1'b1, 11);
      repeat (10) settle();
      chk("good_count", n_acc - a0, 1);
      chk("good_code", a_code, 8'h1C);
      chk("good_ext", a_ext, 0);
      chk("good_rel", a_rel, 0);
      chk("good_no_err", n_err - e0, 0);
      chk("good_latency", rise_cyc - last_drive, 5);

      a0 = n_acc;
      send_frame(8'hE0, 1'b0, 1'b1, 11);
      send_frame(8'hF0, 1'b0, 1'b1, 11);
      send_frame(8'h75, 1'b0, 1'b1, 11);
      repeat (10) settle();
      chk("prefix_count", n_acc - a0, 1);
      chk("prefix_code", a_code, 8'h75);
      chk("prefix_ext", a_ext, 1);
      chk("prefix_rel", a_rel, 1);
      send_frame(8'h1C, 1'b0, 1'b1, 11);
      repeat (10) settle();
      chk("after_prefix_ext", a_ext, 0);
      chk("after_prefix_rel", a_rel, 0);

      a0 = n_acc; e0 = n_err;
      send_frame(8'h1C, 1'b1, 1'b1, 11);
      repeat (10) settle();
      chk("parity_err_count", n_err - e0, 1);
      chk("parity_err_code", last_ecode, 2'b10);
      send_frame(8'h1C, 1'b0, 1'b0, 11);
      repeat (10) settle();
      chk("stop_err_count", n_err - e0, 2);
      chk("stop_err_code", last_ecode, 2'b11);
      chk("err_no_event", n_acc - a0, 0);

      e0 = n_err;
      send_bit(1'b1);
      repeat (10) settle();
      chk("start_err_count", n_err - e0, 1);
      chk("start_err_code", last_ecode, 2'b01);

      e0 = n_err;
      send_frame(8'h1C, 1'b0, 1'b1, 5);
      repeat (TO + 10) settle();
      chk("timeout_count", n_err - e0, 1);
      chk("timeout_code", last_ecode, 2'b00);
      chk("timeout_cycle", last_ecyc - last_drive, TO + 3);
      send_frame(8'h29, 1'b0, 1'b1, 11);
      repeat (10) settle();
      chk("post_timeout_code", a_code, 8'h29);

      @(negedge CLK);
      KEY_READY = 1'b0;
      send_frame(8'h1C, 1'b0, 1'b1, 11);
      send_frame(8'h32, 1'b0, 1'b1, 11);
      repeat (8) settle();
      chk("ovr_valid", KEY_VALID, 1);
      chk("ovr_code_kept", KEY_CODE, 8'h1C);
      chk("ovr_set", OVERRUN, 1);
      @(negedge CLK);
      KEY_READY = 1'b1;
      repeat (3) settle();
      chk("ovr_drained", KEY_VALID, 0);
      chk("ovr_still_set", OVERRUN, 1);
      @(negedge CLK);
      OVR_CLR = 1'b1;
      @(negedge CLK);
      OVR_CLR = 1'b0;
      settle();
      chk("ovr_cleared", OVERRUN, 0);

      @(negedge CLK);
      KEY_READY = 1'b0;
      send_frame(8'h29, 1'b0, 1'b1, 11);
      repeat (8) settle();
      send_frame(8'h1C, 1'b0, 1'b1, 3);
      @(negedge CLK);
      #2 RST = 1'b1;
      #1;
      chk("arst_key_valid", KEY_VALID, 0);
      chk("arst_key_code", KEY_CODE, 0);
      chk("arst_frame_err", FRAME_ERR, 0);
      chk("arst_overrun", OVERRUN, 0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      KEY_READY = 1'b1;
      repeat (5) settle();
      a0 = n_acc; e0 = n_err;
      send_frame(8'h1C, 1'b0, 1'b1, 11);
      repeat (10) settle();
      chk("arst_frame_count", n_acc - a0, 1);
      chk("arst_frame_code", a_code, 8'h1C);
      chk("arst_no_err", n_err - e0, 0);

      rand_rdy = 1'b1;
      run_random(120);
      @(negedge CLK);
      rand_rdy = 1'b0;
      stall = 1'b0;
      KEY_READY = 1'b1;
      OVR_CLR = 1'b0;
      repeat (40) settle();
      chk("model_drained", evq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog actual=timeout expected=finish cyc=%0d", cyc);
      $fatal(1);
   end

endmodule
